regfile_rename: RTL
===================

Name: regfile_rename

Overview:
- Parametrised architectural register file with per-register rename status (busy bit plus owning ROB tag). Successor to the combinational status-lookup file.
- Sits between Decoder/dispatch and RsvStation:
  - Supplies operand values or producer ROB tags for rs1/rs2.
  - Records rd renaming on issue.
  - Retires ROB commits into architectural state.
  - Clears all renaming on flush (mispredict).

Parameters:
- REG_NUM, 32: number of architectural registers; index 0 is hardwired zero.
- REG_IDX_W, 5: register index width, $clog2(REG_NUM).
- DATA_W, 32: register data width.
- ROB_ID_W, 4: ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; state frozen when low.
- ID_issue_valid  in  1  dispatch of one instruction this cycle.
- ID_rd  in  REG_IDX_W  destination register (0 = none).
- ID_rob_id  in  ROB_ID_W  ROB tag allocated to the issuing instruction.
- ID_rs1  in  REG_IDX_W  source 1 index.
- ID_rs2  in  REG_IDX_W  source 2 index.
- ROB_commit_valid  in  1  ROB retires one instruction.
- ROB_commit_rd  in  REG_IDX_W  retiring destination.
- ROB_commit_rob_id  in  ROB_ID_W  retiring tag.
- ROB_commit_data  in  DATA_W  retiring result.
- ROB_flush  in  1  mispredict/flush; discard all renaming.
- RS_rs1_valid  out  1  1 = RS_reg_rs1 holds the value; 0 = wait on RS_rs1_ROB_id.
- RS_reg_rs1  out  DATA_W  rs1 value (0 when not valid).
- RS_rs1_ROB_id  out  ROB_ID_W  rs1 producer tag (0 when valid).
- RS_rs2_valid / RS_reg_rs2 / RS_rs2_ROB_id: same semantics for rs2.

Behaviour:
- Storage: reg[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (async, rst=1): all reg=0, busy=0, tag=0. Outputs are combinational from state, so during reset they read valid=1, data=0, tag=0.
- Reads are combinational, 0-cycle latency, evaluated against the current-cycle state plus same-cycle commit bypass. Priority per operand:
  1. Index 0 → valid=1, data=0.
  2. busy[rs]=0 → valid=1, data=reg[rs].
  3. busy[rs]=1, ROB_commit_valid, commit_rd==rs, commit_rob_id==tag[rs] → valid=1, data=ROB_commit_data (commit bypass).
  4. Otherwise → valid=0, ROB_id=tag[rs], data=0.
- Issue/rd self-dependence: reads are NOT affected by same-cycle issue. An instruction with rs1==rd sees the older producer, never itself.
- Posedge update, only when rdy=1:
  - Commit (valid, rd≠0): reg[rd] <= data unconditionally. busy[rd] <= 0 only if tag[rd]==commit_rob_id; otherwise a younger rename stands.
  - Issue (valid, rd≠0): busy[rd] <= 1, tag[rd] <= ID_rob_id.
  - Same rd issue+commit in one cycle: issue wins busy/tag; commit data is still written.
  - Flush: all busy <= 0 and tags cleared. Same-cycle commit data is still written. Same-cycle issue is ignored.
- Writes to register 0 are ignored; busy[0] stays 0.
- rdy=0: no state change; reads still combinational.
- Reset mid-operation: all renaming lost immediately; no pending write survives.

Optional Feature:
- Macro REGFILE_CDB_BYPASS_EN.
- Defined: adds ports CDB_valid (1), CDB_ROB_id (ROB_ID_W), CDB_data (DATA_W). For any busy operand with tag[rs]==CDB_ROB_id while CDB_valid=1, output valid=1 and data=CDB_data. Priority is below commit bypass. No state update from the CDB.
- Undefined: ports absent; rule 3 is the only bypass.

Decomposition:
- Shared package/defines: REG_NUM, REG_IDX_W, DATA_W, ROB_ID_W, True/False constants, RegIndexBus/ROBIDBus ranges.
- One sub-module, regfile_read_port: the combinational operand-resolve logic, instantiated twice (rs1, rs2).
- Storage and update logic stay in the top module.

Test Plan:
- Reset, then read rs1=5, rs2=0 → both valid=1, data=0.
- Issue rd=3 tag=7; next cycle read rs1=3 → valid=0, ROB_id=7. Commit rd=3 tag=7 data=0xDEAD same cycle as read → valid=1, data=0xDEAD. Next cycle busy clear, reg[3]=0xDEAD.
- Issue rd=4 tag=2, then rd=4 tag=5; commit rd=4 tag=2 data=0x11 → reg[4]=0x11, rs1=4 reads valid=0, ROB_id=5.
- Same-cycle issue rd=6 tag=9 and commit rd=6 (tag matching old owner 1) data=0x22 → reg[6]=0x22, busy[6]=1, tag=9.
- Issue rd=8 tag=3, rd=9 tag=4; assert ROB_flush → next cycle rs1=8, rs2=9 valid=1 with old values. Issue rd=0 tag=1 → read 0 still valid, data 0.
- rdy=0 with issue rd=10 tag=6 → no change. With REGFILE_CDB_BYPASS_EN: busy rd=10 tag=6, CDB tag=6 data=0x33 → valid=1, data=0x33.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared widths, index/tag/data types and boolean constants for the rename register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_rename_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = $clog2(REG_NUM);
  localparam int DATA_W    = 32;
  localparam int ROB_ID_W  = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [REG_IDX_W-1:0] RegIndexBus;
  typedef logic [ROB_ID_W-1:0]  ROBIDBus;
  typedef logic [DATA_W-1:0]    DataBus;

  // Resolved operand as handed to the reservation station.
  typedef struct packed {
    logic    vld;
    DataBus  dat;
    ROBIDBus rob_id;
  } operand_t;

endpackage

// File: rtl/regfile_read_port.sv
// Resolves one source operand to a value or a producer ROB tag (optional CDB bypass: REGFILE_CDB_BYPASS_EN).
// Latency: 0 cycles, purely combinational from the register state and same-cycle commit.
// Backpressure: none; the result is valid every cycle.
module regfile_read_port
  import regfile_rename_pkg::*;
#(
  parameter int IDX_W = REG_IDX_W,
  parameter int D_W   = DATA_W,
  parameter int TAG_W = ROB_ID_W
) (
  input  logic [IDX_W-1:0] i_rs,
  input  logic             i_busy,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [D_W-1:0]   i_reg,
  input  logic             i_commit_vld,
  input  logic [IDX_W-1:0] i_commit_rd,
  input  logic [TAG_W-1:0] i_commit_rob_id,
  input  logic [D_W-1:0]   i_commit_dat,
`ifdef REGFILE_CDB_BYPASS_EN
  input  logic             i_cdb_vld,
  input  logic [TAG_W-1:0] i_cdb_rob_id,
  input  logic [D_W-1:0]   i_cdb_dat,
`endif
  output logic             o_vld,
  output logic [D_W-1:0]   o_dat,
  output logic [TAG_W-1:0] o_rob_id
);

  logic w_is_zero;
  logic w_commit_hit;
  assign w_is_zero    = (i_rs == '0);
  assign w_commit_hit = i_commit_vld && (i_commit_rd == i_rs) && (i_commit_rob_id == i_tag);

`ifdef REGFILE_CDB_BYPASS_EN
  logic w_cdb_hit;
  assign w_cdb_hit = i_cdb_vld && (i_cdb_rob_id == i_tag);
`endif

  // Priority: x0, clean register, retiring producer, (CDB broadcast), else wait on tag.
  always_comb begin
    o_vld    = FALSE;
    o_dat    = '0;
    o_rob_id = '0;
    if (w_is_zero) begin
      o_vld = TRUE;
    end else if (!i_busy) begin
      o_vld = TRUE;
      o_dat = i_reg;
    end else if (w_commit_hit) begin
      o_vld = TRUE;
      o_dat = i_commit_dat;
`ifdef REGFILE_CDB_BYPASS_EN
    end else if (w_cdb_hit) begin
      o_vld = TRUE;
      o_dat = i_cdb_dat;
`endif
    end else begin
      o_rob_id = i_tag;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy bit and owning ROB tag (optional CDB bypass: REGFILE_CDB_BYPASS_EN).
// Latency: operand reads 0 cycles (combinational); issue/commit/flush take effect at the next clk edge.
// Backpressure: rdy low freezes all state; reads stay live.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM   = regfile_rename_pkg::REG_NUM,
  parameter int REG_IDX_W = regfile_rename_pkg::REG_IDX_W,
  parameter int DATA_W    = regfile_rename_pkg::DATA_W,
  parameter int ROB_ID_W  = regfile_rename_pkg::ROB_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 ID_issue_valid,
  input  logic [REG_IDX_W-1:0] ID_rd,
  input  logic [ROB_ID_W-1:0]  ID_rob_id,
  input  logic [REG_IDX_W-1:0] ID_rs1,
  input  logic [REG_IDX_W-1:0] ID_rs2,
  input  logic                 ROB_commit_valid,
  input  logic [REG_IDX_W-1:0] ROB_commit_rd,
  input  logic [ROB_ID_W-1:0]  ROB_commit_rob_id,
  input  logic [DATA_W-1:0]    ROB_commit_data,
  input  logic                 ROB_flush,
`ifdef REGFILE_CDB_BYPASS_EN
  input  logic                 CDB_valid,
  input  logic [ROB_ID_W-1:0]  CDB_ROB_id,
  input  logic [DATA_W-1:0]    CDB_data,
`endif
  output logic                 RS_rs1_valid,
  output logic [DATA_W-1:0]    RS_reg_rs1,
  output logic [ROB_ID_W-1:0]  RS_rs1_ROB_id,
  output logic                 RS_rs2_valid,
  output logic [DATA_W-1:0]    RS_reg_rs2,
  output logic [ROB_ID_W-1:0]  RS_rs2_ROB_id
);

  logic [DATA_W-1:0]   r_reg  [REG_NUM];
  logic                r_busy [REG_NUM];
  logic [ROB_ID_W-1:0] r_tag  [REG_NUM];

  logic w_commit_en;
  logic w_issue_en;
  assign w_commit_en = ROB_commit_valid && (ROB_commit_rd != '0);
  assign w_issue_en  = ID_issue_valid && (ID_rd != '0) && !ROB_flush;

  // State update: commit first, then flush or issue override busy/tag on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_reg[i]  <= '0;
        r_busy[i] <= FALSE;
        r_tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (w_commit_en) begin
        r_reg[ROB_commit_rd] <= ROB_commit_data;
        // An older producer retiring must not release a younger rename.
        if (r_tag[ROB_commit_rd] == ROB_commit_rob_id) begin
          r_busy[ROB_commit_rd] <= FALSE;
        end
      end
      if (ROB_flush) begin
        for (int i = 0; i < REG_NUM; i++) begin
          r_busy[i] <= FALSE;
          r_tag[i]  <= '0;
        end
      end else if (w_issue_en) begin
        r_busy[ID_rd] <= TRUE;
        r_tag[ID_rd]  <= ID_rob_id;
      end
    end
  end

  regfile_read_port #(
    .IDX_W (REG_IDX_W),
    .D_W   (DATA_W),
    .TAG_W (ROB_ID_W)
  ) u_rd_rs1 (
    .i_rs            (ID_rs1),
    .i_busy          (r_busy[ID_rs1]),
    .i_tag           (r_tag[ID_rs1]),
    .i_reg           (r_reg[ID_rs1]),
    .i_commit_vld    (ROB_commit_valid),
    .i_commit_rd     (ROB_commit_rd),
    .i_commit_rob_id (ROB_commit_rob_id),
    .i_commit_dat    (ROB_commit_data),
`ifdef REGFILE_CDB_BYPASS_EN
    .i_cdb_vld       (CDB_valid),
    .i_cdb_rob_id    (CDB_ROB_id),
    .i_cdb_dat       (CDB_data),
`endif
    .o_vld           (RS_rs1_valid),
    .o_dat           (RS_reg_rs1),
    .o_rob_id        (RS_rs1_ROB_id)
  );

  regfile_read_port #(
    .IDX_W (REG_IDX_W),
    .D_W   (DATA_W),
    .TAG_W (ROB_ID_W)
  ) u_rd_rs2 (
    .i_rs            (ID_rs2),
    .i_busy          (r_busy[ID_rs2]),
    .i_tag           (r_tag[ID_rs2]),
    .i_reg           (r_reg[ID_rs2]),
    .i_commit_vld    (ROB_commit_valid),
    .i_commit_rd     (ROB_commit_rd),
    .i_commit_rob_id (ROB_commit_rob_id),
    .i_commit_dat    (ROB_commit_data),
`ifdef REGFILE_CDB_BYPASS_EN
    .i_cdb_vld       (CDB_valid),
    .i_cdb_rob_id    (CDB_ROB_id),
    .i_cdb_dat       (CDB_data),
`endif
    .o_vld           (RS_rs2_valid),
    .o_dat           (RS_reg_rs2),
    .o_rob_id        (RS_rs2_ROB_id)
  );

endmodule
